// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and encodings for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic {IDLE, ACCESS} state_t;
    typedef enum logic {REQ_IF, REQ_DM} requester_t;

    localparam logic [1:0] ACC_WORD = 2'b00;
    localparam logic       RW_READ  = 1'b1;
    localparam logic       RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
// Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RD_LATENCY     = 1,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic [31:0] dm_addr,
    input  logic        dm_rd_wr,
    input  logic [31:0] dm_wdata,
    input  logic [1:0]  dm_size,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [1:0]  mem_size,
    output logic        mem_rd_wr,
    output logic        mem_en,
    input  logic [31:0] mem_dout
);

    localparam int CW = $clog2(RD_LATENCY + 1);

    state_t         state;
    requester_t     owner;
    logic [CW-1:0]  cnt;
    logic           idle_ok;
    logic           force_if;
    logic           grant_dm;
    logic           grant_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int BW = $clog2(MAX_DATA_BURST + 1);
    logic [BW-1:0] data_run;

    assign force_if = if_req && (data_run == BW'(MAX_DATA_BURST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_run <= '0;
        end else if (!if_req || grant_if) begin
            data_run <= '0;
        end else if (grant_dm) begin
            data_run <= data_run + BW'(1);
        end
    end
`else
    assign force_if = 1'b0;
`endif

    // Grants are combinational and only ever issued from IDLE; data is older, so it wins.
    always_comb begin
        idle_ok  = (state == IDLE) && !reset;
        grant_dm = idle_ok && dm_req && !force_if;
        grant_if = idle_ok && if_req && !grant_dm;
    end

    assign if_gnt = grant_if;
    assign dm_gnt = grant_dm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= REQ_IF;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_rd_wr <= RW_READ;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_size  <= ACC_WORD;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state     <= ACCESS;
                        owner     <= REQ_DM;
                        mem_en    <= 1'b1;
                        mem_addr  <= dm_addr;
                        mem_din   <= dm_wdata;
                        mem_size  <= dm_size;
                        mem_rd_wr <= dm_rd_wr;
                        cnt       <= (dm_rd_wr == RW_WRITE) ? CW'(1) : CW'(RD_LATENCY);
                    end else if (grant_if) begin
                        state     <= ACCESS;
                        owner     <= REQ_IF;
                        mem_en    <= 1'b1;
                        mem_addr  <= if_addr;
                        mem_size  <= ACC_WORD;
                        mem_rd_wr <= RW_READ;
                        cnt       <= CW'(RD_LATENCY);
                    end
                end
                ACCESS: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= IDLE;
                        mem_en    <= 1'b0;
                        mem_rd_wr <= RW_READ;
                        if (mem_rd_wr == RW_READ) begin
                            if (owner == REQ_IF) begin
                                if_rdata  <= mem_dout;
                                if_rvalid <= 1'b1;
                            end else begin
                                dm_rdata  <= mem_dout;
                                dm_rvalid <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
